fp_round_pack: RTL
==================

FP_ROUND_PACK -- requirements
Module: fp_round_pack

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the saturation event counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream word present.
REQ-005 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-006 SHALL have port sign_in  input  1  sign of original two's-complement sample.
REQ-007 SHALL have port mag_in  input  12  unsigned magnitude (0..2048).
REQ-008 SHALL have port exp_in  input  3  exponent from the exponent stage (0..7).
REQ-009 SHALL have port out_valid  output  1  packed result present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port S  output  1  result sign.
REQ-012 SHALL have port E  output  3  result exponent.
REQ-013 SHALL have port F  output  4  result significand; value = F * 2^E.
REQ-014 SHALL have port sat_cnt  output  CNT_W  count of saturated results delivered.

Function
REQ-015 SHALL transfer a word in when in_valid && in_ready, and out when out_valid && out_ready.
REQ-016 SHALL be a 2-stage pipeline: S1 registers inputs, S2 registers rounded/packed result.
REQ-017 SHALL present out_valid exactly 2 cycles after acceptance when out_ready is held high; throughput 1 word/cycle.
REQ-018 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready (combinational, no input-to-input path except out_ready).
REQ-019 SHALL hold S, E, F stable while out_valid && !out_ready; no word dropped or duplicated under any stall pattern.
REQ-020 SHALL extract significand raw = mag[E+3:E] and round bit r = mag[E-1] for E>0; r = 0 for E=0.
REQ-021 SHALL round half-up: F = raw + r when raw + r <= 15.
REQ-022 SHALL on raw=15 and r=1 with E<7 output F=8, E=E+1.
REQ-023 SHALL on raw=15 and r=1 with E=7 saturate to F=15, E=7.
REQ-024 SHALL on mag[11]=1 (mag 2048) saturate to F=15, E=7 regardless of exp_in.
REQ-025 SHALL pass S = sign_in unchanged, including for mag 0 (F=0, E=0).
REQ-026 SHALL increment sat_cnt on each delivered saturated result (REQ-023/024), holding at all-ones.
REQ-027 SHALL count a saturated result once only, on its out handshake, not while stalled.

Reset
REQ-028 SHALL on rst_n low immediately clear s1_valid, s2_valid, out_valid, S, E, F and sat_cnt to 0.
REQ-029 SHALL discard in-flight words on reset mid-operation; first post-reset output is from a word accepted after release.
REQ-030 SHALL drive in_ready high during reset and in the first cycle after release.

Structure
REQ-031 SHALL place MAG_W=12, EXP_W=3, SIG_W=4, EXP_MAX=7 and SIG_MAX=15 in shared package fp_pkg.
REQ-032 SHALL place the combinational extract/round/saturate logic in one sub-module, fp_round, instantiated between S1 and S2.

Verification
REQ-033 SHALL test mag=45 (000000101101), exp=3, sign=0 -> F=0110, E=011, S=0 after 2 cycles.
REQ-034 SHALL test mag=252 (000011111100), exp=4 -> round carry F=1000, E=101; sat_cnt unchanged.
REQ-035 SHALL test mag=2048, exp=7, sign=1 and mag=2047, exp=7 -> both F=1111, E=111; sat_cnt 0->2.
REQ-036 SHALL test mag=5, exp=0 -> F=0101, E=000; mag=0, sign=1 -> F=0000, E=000, S=1.
REQ-037 SHALL test a 6-word stream with out_ready toggling 1,0,0,1,0,1...: outputs in order, each once, in_ready low only when both stages full and out_ready=0.
REQ-038 SHALL test rst_n pulsed low with both stages full: out_valid=0 and sat_cnt=0 at once; next output matches first post-reset input.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared widths, limits and the request/result structs for the
// round-and-pack datapath.
package fp_pkg;
  localparam int MAG_W = 12;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam logic [EXP_W-1:0] EXP_MAX = 3'd7;
  localparam logic [SIG_W-1:0] SIG_MAX = 4'd15;

  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
    logic [EXP_W-1:0] exp;
  } fp_req_t;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] f;
    logic             sat;
  } fp_rsp_t;
endpackage

// File: rtl/fp_round.sv
// Combinational significand extract, half-up round and saturation.
module fp_round
  import fp_pkg::*;
(
  input  fp_req_t req,
  output fp_rsp_t rsp
);
  logic [MAG_W:0] ext;
  logic [SIG_W:0] sum;

  always_comb begin
    // Appending a zero LSB makes ext[0] the round bit, and 0 when exp==0.
    ext     = {req.mag, 1'b0} >> req.exp;
    sum     = {1'b0, ext[SIG_W:1]} + {{SIG_W{1'b0}}, ext[0]};
    rsp.s   = req.sign;
    rsp.e   = req.exp;
    rsp.f   = sum[SIG_W-1:0];
    rsp.sat = 1'b0;
    if (req.mag[MAG_W-1]) begin
      rsp.e   = EXP_MAX;
      rsp.f   = SIG_MAX;
      rsp.sat = 1'b1;
    end else if (sum[SIG_W]) begin
      if (req.exp == EXP_MAX) begin
        rsp.f   = SIG_MAX;
        rsp.sat = 1'b1;
      end else begin
        rsp.e = req.exp + 1'b1;
        rsp.f = {1'b1, {(SIG_W-1){1'b0}}};
      end
    end
  end
endmodule

// File: rtl/fp_round_pack.sv
// Two-stage valid/ready pipeline: S1 holds the raw word, S2 the packed
// result; counts saturated results as they leave.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [MAG_W-1:0] mag_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             S,
  output logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F,
  output logic [CNT_W-1:0] sat_cnt
);
  logic    s1_valid, s2_valid, s2_sat, s2_adv;
  fp_req_t s1_q;
  fp_rsp_t rnd;

  assign s2_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || !s2_valid || out_ready;
  assign out_valid = s2_valid;

  // in_ready implies S1 is either empty or moving into S2 this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_q <= '{sign: sign_in, mag: mag_in, exp: exp_in};
    end
  end

  fp_round u_round (
    .req (s1_q),
    .rsp (rnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      S        <= 1'b0;
      E        <= '0;
      F        <= '0;
      s2_sat   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) {S, E, F, s2_sat} <= rnd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_cnt <= '0;
    else if (s2_valid && out_ready && s2_sat && (sat_cnt != '1))
      sat_cnt <= sat_cnt + 1'b1;
  end
endmodule
